multicycle_controller: RTL and testbench

Multi-cycle sequencer for the 19-bit processor datapath. It fetches an instruction over a req/ack instruction-memory handshake and latches it in an internal instruction register (IR). It decodes IR[18:14] and drives the datapath select, ALU, shift/rotate, flag-enable, register-write and data-memory controls over FETCH/DECODE/EXEC/MEM/WB states. It replaces the combinational per-instruction controller and adds wait-state memories, branches, jumps and bus-timeout handling.

---
 rtl/multicycle_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the 19-bit datapath.
// Fetch/decode/exec/mem/wb with ack timeouts.
module multicycle_controller #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [18:0] instr_in,
  input  logic        instr_ack,
  input  logic        data_ack,
  input  logic        zero_flag,
  input  logic        carry_flag,
  output logic        instr_req,
  output logic        ir_load,
  output logic        enablePC,
  output logic [1:0]  pcSelect,
  output logic        regWrite,
  output logic [1:0]  selectToWrite,
  output logic        selectR2,
  output logic        selectAluArg,
  output logic [2:0]  ALUfunction,
  output logic [1:0]  sh_roFunction,
  output logic        enableZero,
  output logic        enableCarry,
  output logic        memRead,
  output logic        memWrite,
  output logic        illegal,
  output logic        bus_error,
  output logic [2:0]  state
);

  localparam int CW =
    (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO = CW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_SH,
    C_LDM,
    C_STM,
    C_BR,
    C_JMP,
    C_ILL
  } cls_t;

  state_t        cur;
  state_t        nxt;
  cls_t          cls;
  logic [18:0]   ir;
  logic [CW-1:0] cnt;
  logic [4:0]    op;
  logic          ack;
  logic          waiting;
  logic          timeout;
  logic          taken;

  assign op      = ir[18:14];
  assign waiting = (cur == S_FETCH) || (cur == S_MEM);
  assign ack     = (cur == S_FETCH) ? instr_ack : data_ack;
  // ack in the expiry cycle wins over the timeout
  assign timeout = (ACK_TIMEOUT != 0) && waiting &&
                   !ack && (cnt == TO);
  assign state   = cur;

  // classify the latched opcode
  always_comb begin
    cls = C_ILL;
    casez (op)
      5'b0????: cls = C_ALU;
      5'b110??: cls = C_SH;
      5'b10000: cls = C_LDM;
      5'b10001: cls = C_STM;
      5'b101??: cls = C_BR;
      5'b11100: cls = C_JMP;
      default:  cls = C_ILL;
    endcase
  end

  // branch condition on the live flags
  always_comb begin
    taken = 1'b0;
    case (op[1:0])
      2'b00: taken = zero_flag;
      2'b01: taken = ~zero_flag;
      2'b10: taken = carry_flag;
      2'b11: taken = ~carry_flag;
      default: taken = 1'b0;
    endcase
  end

  // next state and all control outputs
  always_comb begin
    nxt           = cur;
    instr_req     = 1'b0;
    ir_load       = 1'b0;
    enablePC      = 1'b0;
    pcSelect      = 2'b00;
    regWrite      = 1'b0;
    selectToWrite = 2'b00;
    selectR2      = 1'b0;
    selectAluArg  = 1'b0;
    ALUfunction   = 3'b000;
    sh_roFunction = 2'b00;
    enableZero    = 1'b0;
    enableCarry   = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    illegal       = 1'b0;
    bus_error     = 1'b0;

    if (cur == S_DECODE || cur == S_EXEC ||
        cur == S_MEM || cur == S_WB) begin
      case (cls)
        C_ALU: begin
          ALUfunction  = op[2:0];
          selectAluArg = ~op[3];
          selectR2     = 1'b1;
        end
        C_SH: begin
          sh_roFunction = op[1:0];
          selectToWrite = 2'b01;
        end
        C_LDM: selectToWrite = 2'b10;
        default: ;
      endcase
    end

    case (cur)
      S_INIT: nxt = S_FETCH;
      S_FETCH: begin
        if (timeout) begin
          bus_error = 1'b1;
          nxt       = S_FETCH;
        end else begin
          instr_req = 1'b1;
          if (instr_ack) begin
            ir_load = 1'b1;
            nxt     = S_DECODE;
          end
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        nxt = S_FETCH;
        case (cls)
          C_ALU: begin
            regWrite    = 1'b1;
            enableZero  = 1'b1;
            enableCarry = 1'b1;
            enablePC    = 1'b1;
          end
          C_SH: begin
            regWrite = 1'b1;
            enablePC = 1'b1;
          end
          C_BR: begin
            enablePC = 1'b1;
            pcSelect = taken ? 2'b01 : 2'b00;
          end
          C_JMP: begin
            enablePC = 1'b1;
            pcSelect = 2'b10;
          end
          C_LDM, C_STM: nxt = S_MEM;
          default: begin
            illegal  = 1'b1;
            enablePC = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          bus_error = 1'b1;
          enablePC  = 1'b1;
          nxt       = S_FETCH;
        end else if (cls == C_LDM) begin
          memRead = 1'b1;
          if (data_ack) nxt = S_WB;
        end else begin
          memWrite = 1'b1;
          if (data_ack) begin
            enablePC = 1'b1;
            nxt      = S_FETCH;
          end
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        enablePC = 1'b1;
        nxt      = S_FETCH;
      end
      default: nxt = S_INIT;
    endcase
  end

  // state, IR and ack-wait counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur <= S_INIT;
      ir  <= '0;
      cnt <= '0;
    end else begin
      cur <= nxt;
      if (ir_load) ir <= instr_in;
      if (nxt != cur || timeout)
        cnt <= '0;
      else if (waiting && !ack && ACK_TIMEOUT != 0)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller.
// Transaction-level model expands each instruction.
module tb_multicycle_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [18:0] instr_in;
  logic        instr_ack;
  logic        data_ack;
  logic        zero_flag;
  logic        carry_flag;
  logic        instr_req;
  logic        ir_load;
  logic        enablePC;
  logic [1:0]  pcSelect;
  logic        regWrite;
  logic [1:0]  selectToWrite;
  logic        selectR2;
  logic        selectAluArg;
  logic [2:0]  ALUfunction;
  logic [1:0]  sh_roFunction;
  logic        enableZero;
  logic        enableCarry;
  logic        memRead;
  logic        memWrite;
  logic        illegal;
  logic        bus_error;
  logic [2:0]  state;

  multicycle_controller #(.ACK_TIMEOUT(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .instr_in(instr_in),
    .instr_ack(instr_ack),
    .data_ack(data_ack),
    .zero_flag(zero_flag),
    .carry_flag(carry_flag),
    .instr_req(instr_req),
    .ir_load(ir_load),
    .enablePC(enablePC),
    .pcSelect(pcSelect),
    .regWrite(regWrite),
    .selectToWrite(selectToWrite),
    .selectR2(selectR2),
    .selectAluArg(selectAluArg),
    .ALUfunction(ALUfunction),
    .sh_roFunction(sh_roFunction),
    .enableZero(enableZero),
    .enableCarry(enableCarry),
    .memRead(memRead),
    .memWrite(memWrite),
    .illegal(illegal),
    .bus_error(bus_error),
    .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       req;
    logic       irl;
    logic       epc;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] stw;
    logic       r2;
    logic       aa;
    logic [2:0] af;
    logic [1:0] sf;
    logic       ez;
    logic       ec;
    logic       mr;
    logic       mw;
    logic       il;
    logic       be;
    logic [2:0] st;
  } o_t;

  typedef struct {
    o_t          o;
    logic        ia;
    logic        da;
    logic [18:0] ins;
  } step_t;

  localparam int TMO = 4;

  step_t plan[$];
  o_t    cur;
  logic  cur_valid = 1'b0;
  int    checks = 0;
  int    passed = 0;

  function automatic o_t dut_o();
    o_t r;
    r.req = instr_req;     r.irl = ir_load;
    r.epc = enablePC;      r.pcs = pcSelect;
    r.rw  = regWrite;      r.stw = selectToWrite;
    r.r2  = selectR2;      r.aa  = selectAluArg;
    r.af  = ALUfunction;   r.sf  = sh_roFunction;
    r.ez  = enableZero;    r.ec  = enableCarry;
    r.mr  = memRead;       r.mw  = memWrite;
    r.il  = illegal;       r.be  = bus_error;
    r.st  = state;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h t=%0t",
                  name, got, exp, $time);
  endtask

  // per-cycle comparison against the planned outputs
  always @(negedge clock)
    if (cur_valid)
      chk($sformatf("cycle_st%0d", cur.st), dut_o(), cur);

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // 0 alu 1 shift 2 ldm 3 stm 4 branch 5 jmp 6 illegal
  function automatic int kind(input logic [18:0] ins);
    logic [4:0] op;
    op = ins[18:14];
    if (op[4] == 1'b0) return 0;
    if (op[4:2] == 3'b110) return 1;
    if (op == 5'b10000) return 2;
    if (op == 5'b10001) return 3;
    if (op[4:2] == 3'b101) return 4;
    if (op == 5'b11100) return 5;
    return 6;
  endfunction

  function automatic o_t sel_of(input logic [18:0] ins,
                                input logic [2:0] st);
    o_t o;
    int k;
    o = '0;
    o.st = st;
    k = kind(ins);
    if (k == 0) begin
      o.af = ins[16:14];
      o.aa = ~ins[17];
      o.r2 = 1'b1;
    end else if (k == 1) begin
      o.sf  = ins[15:14];
      o.stw = 2'b01;
    end else if (k == 2) begin
      o.stw = 2'b10;
    end
    return o;
  endfunction

  task automatic push(input o_t o, input logic ia,
                      input logic da, input logic [18:0] ins);
    step_t s;
    s.o = o; s.ia = ia; s.da = da; s.ins = ins;
    plan.push_back(s);
  endtask

  task automatic expand(input logic [18:0] ins,
                        input int fw, input int dw,
                        input logic z, input logic c);
    o_t o;
    o_t t;
    int w;
    int k;
    int n;
    logic tk;
    plan.delete();
    k = kind(ins);
    w = fw;
    while (1) begin
      o = '0; o.st = 3'd1; o.req = 1'b1;
      n = (w > TMO) ? TMO : w;
      for (int i = 0; i < n; i++)
        push(o, 1'b0, rb(), 19'($urandom));
      if (w > TMO) begin
        t = '0; t.st = 3'd1; t.be = 1'b1;
        push(t, 1'b0, rb(), 19'($urandom));
        w = w - TMO - 1;
      end else begin
        o.irl = 1'b1;
        push(o, 1'b1, rb(), ins);
        break;
      end
    end
    push(sel_of(ins, 3'd2), rb(), rb(), 19'($urandom));
    o = sel_of(ins, 3'd3);
    case (k)
      0: begin
        o.rw = 1'b1; o.ez = 1'b1; o.ec = 1'b1; o.epc = 1'b1;
      end
      1: begin o.rw = 1'b1; o.epc = 1'b1; end
      4: begin
        case (ins[15:14])
          2'b00: tk = z;
          2'b01: tk = ~z;
          2'b10: tk = c;
          default: tk = ~c;
        endcase
        o.epc = 1'b1;
        o.pcs = tk ? 2'b01 : 2'b00;
      end
      5: begin o.epc = 1'b1; o.pcs = 2'b10; end
      6: begin o.il = 1'b1; o.epc = 1'b1; end
      default: ;
    endcase
    push(o, rb(), rb(), 19'($urandom));
    if (k == 2 || k == 3) begin
      o = sel_of(ins, 3'd4);
      if (k == 2) o.mr = 1'b1;
      else o.mw = 1'b1;
      n = (dw > TMO) ? TMO : dw;
      for (int i = 0; i < n; i++)
        push(o, rb(), 1'b0, 19'($urandom));
      if (dw > TMO) begin
        t = sel_of(ins, 3'd4);
        t.be = 1'b1; t.epc = 1'b1;
        push(t, rb(), 1'b0, 19'($urandom));
      end else begin
        if (k == 3) o.epc = 1'b1;
        push(o, rb(), 1'b1, 19'($urandom));
        if (k == 2) begin
          t = sel_of(ins, 3'd5);
          t.rw = 1'b1; t.epc = 1'b1;
          push(t, rb(), rb(), 19'($urandom));
        end
      end
    end
  endtask

  task automatic do_step(input step_t s);
    instr_ack = s.ia;
    data_ack  = s.da;
    instr_in  = s.ins;
    cur       = s.o;
    cur_valid = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    cur_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [18:0] ins,
                         input int fw, input int dw,
                         input logic z, input logic c);
    zero_flag  = z;
    carry_flag = c;
    expand(ins, fw, dw, z, c);
    foreach (plan[i]) do_step(plan[i]);
  endtask

  task automatic init_step();
    step_t s;
    s.o = '0; s.ia = rb(); s.da = rb(); s.ins = 19'($urandom);
    do_step(s);
  endtask

  initial begin
    o_t e;
    int rw_seen;
    reset_n    = 1'b0;
    instr_in   = '0;
    instr_ack  = 1'b0;
    data_ack   = 1'b0;
    zero_flag  = 1'b0;
    carry_flag = 1'b0;

    expand(19'h28000, 0, 0, 1'b0, 1'b0);
    chk("len_alu", plan.size(), 3);
    e = '0; e.st = 3'd3; e.af = 3'b010; e.aa = 1'b0;
    e.r2 = 1'b1; e.rw = 1'b1; e.ez = 1'b1; e.ec = 1'b1;
    e.epc = 1'b1;
    chk("alu_exec_lit", plan[2].o, e);
    expand(19'h40000, 0, 2, 1'b0, 1'b0);
    chk("len_ldm_w2", plan.size(), 7);
    e = '0; e.st = 3'd5; e.stw = 2'b10; e.rw = 1'b1;
    e.epc = 1'b1;
    chk("ldm_wb_lit", plan[6].o, e);
    expand(19'h44000, 0, 0, 1'b0, 1'b0);
    chk("len_stm", plan.size(), 4);
    expand(19'h40000, 0, 6, 1'b0, 1'b0);
    chk("len_ldm_to", plan.size(), 8);
    chk("ldm_to_be", plan[7].o.be, 1);

    repeat (2) @(posedge clock);
    #1;
    chk("reset_zero", dut_o(), 0);
    reset_n = 1'b1;
    init_step();

    run_txn(19'h28000, 0, 0, 1'b0, 1'b1);
    run_txn(19'h40000, 0, 2, 1'b1, 1'b0);
    run_txn(19'h44000, 0, 0, 1'b0, 1'b0);
    run_txn(19'h44000, 1, 3, 1'b1, 1'b1);
    run_txn(19'h68000, 0, 0, 1'b1, 1'b1);
    run_txn(19'h50000, 0, 0, 1'b1, 1'b0);
    run_txn(19'h50000, 0, 0, 1'b0, 1'b0);
    run_txn(19'h54000, 0, 0, 1'b0, 1'b0);
    run_txn(19'h5C000, 0, 0, 1'b0, 1'b1);
    run_txn(19'h70000, 0, 0, 1'b0, 1'b0);
    run_txn(19'h78000, 0, 0, 1'b0, 1'b0);
    run_txn(19'h40000, 0, 6, 1'b0, 1'b0);
    run_txn(19'h40000, 0, 4, 1'b0, 1'b0);
    run_txn(19'h44000, 0, 5, 1'b0, 1'b0);
    run_txn(19'h0C000, 5, 0, 1'b0, 1'b0);
    run_txn(19'h0C000, 4, 0, 1'b0, 1'b0);
    run_txn(19'h60000, 6, 0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [18:0] ins;
      int fw;
      int dw;
      ins = {5'($urandom_range(0, 31)), 14'($urandom)};
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
      dw = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 0;
      run_txn(ins, fw, dw, rb(), rb());
    end

    // asynchronous reset in the middle of a load
    expand(19'h40000, 0, 6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_step(plan[i]);
    instr_ack = 1'b0;
    data_ack  = 1'b0;
    #1;
    chk("pre_rst_memread", memRead, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_zero", dut_o(), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_hold_zero", dut_o(), 0);
    reset_n = 1'b1;
    init_step();

    rw_seen = 0;
    zero_flag  = 1'b0;
    carry_flag = 1'b0;
    expand(19'h44000, 0, 1, 1'b0, 1'b0);
    foreach (plan[i]) begin
      do_step(plan[i]);
      if (regWrite) rw_seen++;
    end
    chk("stm_no_regwrite", rw_seen, 0);
    run_txn(19'h28000, 0, 0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
